// File: rtl/arbitro_validacion.sv
// Round-robin grant of one validate-and-register path among R flag sources.
// Optional CHECK timeout when ARBITRO_TIMEOUT_EN is defined.
module arbitro_validacion #(
  parameter int N       = 8,
  parameter int R       = 4,
  parameter int REF_W   = 9,
  parameter int STABLE  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [R-1:0]         req,
  input  logic [R*N-1:0]       data_in,
  output logic [R-1:0]         ack,
  output logic [REF_W-1:0]     ref_word,
  output logic [$clog2(R)-1:0] ref_src,
  output logic                 ref_valid,
  output logic                 busy,
  output logic                 err,
  output logic [1:0]           fsm_state
);
  // Four-phase handshake: a source raises req and holds it (data steady) until it
  // sees ack; ack then stays high until req is sampled low, and drops on that edge.
  localparam int SW    = $clog2(R);
  localparam int CNT_W = $clog2(STABLE + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;
  localparam logic [1:0] ACK   = 2'd3;

  if (R < 2 || R > 8 || REF_W < N || STABLE < 1 || TIMEOUT < 2) begin : g_param_check
    $error("arbitro_validacion: illegal parameter combination");
  end

  logic [1:0]       state;
  logic [SW-1:0]    grant;
  logic [SW-1:0]    last_grant;
  logic [SW-1:0]    nxt;
  logic             found;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     sample;
  logic [N-1:0]     cur;
  int               j;

  assign busy      = (state != IDLE);
  assign fsm_state = state;
  assign cur       = data_in[grant*N +: N];

  // First pending request searching upward from the one after last_grant.
  always_comb begin
    found = 1'b0;
    nxt   = last_grant;
    j     = 0;
    for (int k = 1; k <= R; k++) begin
      j = (int'(last_grant) + k) % R;
      if (!found && req[j]) begin
        found = 1'b1;
        nxt   = SW'(j);
      end
    end
  end

`ifdef ARBITRO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] tmr;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= SW'(R - 1);
      cnt        <= '0;
      sample     <= '0;
      ref_word   <= '0;
      ref_src    <= '0;
      ref_valid  <= 1'b0;
      ack        <= '0;
      err        <= 1'b0;
`ifdef ARBITRO_TIMEOUT_EN
      tmr        <= '0;
`endif
    end else begin
      ref_valid <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant  <= nxt;
            sample <= data_in[nxt*N +: N];
            cnt    <= '0;
`ifdef ARBITRO_TIMEOUT_EN
            tmr    <= '0;
`endif
            state  <= CHECK;
          end
        end
        CHECK: begin
`ifdef ARBITRO_TIMEOUT_EN
          tmr <= tmr + 1'b1;
`endif
          if (!req[grant]) begin
            last_grant <= grant;
            state      <= IDLE;
          end else if (cur == sample && cnt == CNT_W'(STABLE - 1)) begin
            state <= LOAD;
`ifdef ARBITRO_TIMEOUT_EN
          end else if (tmr == TW'(TIMEOUT - 1)) begin
            err        <= 1'b1;
            last_grant <= grant;
            state      <= IDLE;
`endif
          end else if (cur == sample) begin
            cnt <= cnt + 1'b1;
          end else begin
            // Any change of the word restarts the stability count.
            sample <= cur;
            cnt    <= '0;
          end
        end
        LOAD: begin
          ref_word  <= REF_W'(sample);
          ref_src   <= grant;
          ref_valid <= 1'b1;
          ack       <= R'(1) << grant;
          state     <= ACK;
        end
        ACK: begin
          if (!req[grant]) begin
            ack        <= '0;
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef ARBITRO_TIMEOUT_EN
  logic unused_ok;
  assign unused_ok = 1'b0;
`endif

endmodule

// File: tb/tb_arbitro_validacion.sv
// Directed bench for arbitro_validacion: reset, glitch, fairness, handshake,
// abandon and timeout scenarios with a ref/ref_src scoreboard.
module tb_arbitro_validacion;
  localparam int N       = 8;
  localparam int R       = 4;
  localparam int REF_W   = 9;
  localparam int STABLE  = 4;
  localparam int TIMEOUT = 16;
  localparam int SW      = $clog2(R);
  localparam int W       = SW + REF_W;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [R-1:0]     req = '0;
  logic [R*N-1:0]   data_in = '0;
  logic [R-1:0]     ack;
  logic [REF_W-1:0] ref_word;
  logic [SW-1:0]    ref_src;
  logic             ref_valid;
  logic             busy;
  logic             err;
  logic [1:0]       fsm_state;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];

  arbitro_validacion #(
    .N(N), .R(R), .REF_W(REF_W), .STABLE(STABLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in), .ack(ack),
    .ref_word(ref_word), .ref_src(ref_src), .ref_valid(ref_valid),
    .busy(busy), .err(err), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int src, input logic [N-1:0] v);
    data_in[src*N +: N] = v;
  endtask

  task automatic expect_ref(input int src, input int word);
    exp_q.push_back({SW'(src), REF_W'(word)});
  endtask

  // One clock: inputs were set at a negedge, outputs are looked at on the next one.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ack(input int src);
    for (int i = 0; i < 60; i++) begin
      if (ack[src]) break;
      cyc();
    end
    check("ack_wait", 32'(ack[src]), 1);
  endtask

  // Scoreboard: every ref_valid pulse must match the oldest expected update.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (reset && ref_valid) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("ref_word", 32'(ref_word), 32'(e[REF_W-1:0]));
        check("ref_src", 32'(ref_src), 32'(e[W-1:REF_W]));
        check("ack_onehot", 32'(ack), 32'(1) << e[W-1:REF_W]);
      end
    end
  end

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ref", 32'(ref_word), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    check("rst_valid", 32'(ref_valid), 0);
    reset = 1'b1;

    // Glitch: 55,55,54 then 55 steady; other sources' data scrambled
    expect_ref(0, 'h055);
    req[0] = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      set_data(0, (e == 3) ? 8'h54 : 8'h55);
      set_data(3, 8'($urandom_range(0, 255)));
      cyc();
      check("glitch_valid", 32'(ref_valid), 32'(e == 9));
    end
    req[0] = 1'b0;
    cyc();
    check("glitch_ack_drop", 32'(ack), 0);
    check("glitch_busy", 32'(busy), 0);

    // Reset in the middle of CHECK, then latency from a clean start
    req[1] = 1'b1;
    set_data(1, 8'h3C);
    cyc();
    cyc();
    check("mid_busy_pre", 32'(busy), 1);
    reset = 1'b0;
    #1;
    check("mid_rst_ref", 32'(ref_word), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ack", 32'(ack), 0);
    @(negedge clk);
    reset = 1'b1;
    expect_ref(1, 'h03C);
    for (int e = 1; e <= 6; e++) begin
      cyc();
      check("lat_valid", 32'(ref_valid), 32'(e == 6));
    end
    req[1] = 1'b0;
    cyc();
    check("lat_busy", 32'(busy), 0);

    // Handshake: ack holds while req[3] stays high, no other grant
    expect_ref(3, 'h0A7);
    req[3] = 1'b1;
    set_data(3, 8'hA7);
    for (int e = 1; e <= 6; e++) cyc();
    req[0] = 1'b1;
    set_data(0, 8'h11);
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("hold_ack", 32'(ack), 32'h8);
      check("hold_busy", 32'(busy), 1);
    end
    req[3] = 1'b0;
    cyc();
    check("drop_ack", 32'(ack), 0);
    check("drop_busy", 32'(busy), 0);
    expect_ref(0, 'h011);
    wait_ack(0);
    req[0] = 1'b0;
    cyc();

    // Abandon: req[1] drops in CHECK, pending req[2] served next
    req[1] = 1'b1;
    req[2] = 1'b1;
    set_data(1, 8'h99);
    set_data(2, 8'h22);
    cyc();
    cyc();
    req[1] = 1'b0;
    cyc();
    check("abandon_ack", 32'(ack), 0);
    check("abandon_busy", 32'(busy), 0);
    check("abandon_ref", 32'(ref_word), 'h011);
    expect_ref(2, 'h022);
    wait_ack(2);
    req[2] = 1'b0;
    cyc();

    // Fairness after reset: 0, 2, then 0 again
    reset = 1'b0;
    #1;
    check("fair_rst_ref", 32'(ref_word), 0);
    @(negedge clk);
    reset = 1'b1;
    expect_ref(0, 'h00F);
    expect_ref(2, 'h0F0);
    expect_ref(0, 'h05A);
    req[0] = 1'b1;
    req[2] = 1'b1;
    set_data(0, 8'h0F);
    set_data(2, 8'hF0);
    wait_ack(0);
    req[0] = 1'b0;
    cyc();
    wait_ack(2);
    req[0] = 1'b1;
    set_data(0, 8'h5A);
    cyc();
    req[2] = 1'b0;
    cyc();
    wait_ack(0);
    req[0] = 1'b0;
    cyc();

    // Timeout: data toggles every cycle on source 1
    req[1] = 1'b1;
`ifdef ARBITRO_TIMEOUT_EN
    for (int e = 1; e <= 17; e++) begin
      set_data(1, (e % 2 == 1) ? 8'hAA : 8'h55);
      cyc();
      check("to_err", 32'(err), 32'(e == 17));
      check("to_ack", 32'(ack), 0);
    end
`else
    for (int e = 1; e <= 20; e++) begin
      set_data(1, (e % 2 == 1) ? 8'hAA : 8'h55);
      cyc();
      check("to_err", 32'(err), 0);
      check("to_busy", 32'(busy), 1);
    end
`endif
    req[1] = 1'b0;
    cyc();
    check("to_idle", 32'(busy), 0);
    check("to_ref", 32'(ref_word), 'h05A);

    cyc();
    check("sb_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arbitro_validacion.md
Name: arbitro_validacion

Overview:
- Round-robin controller that shares one validate-and-register path among R flag sources.
- Grants one requester at a time and checks that its flag word holds steady for STABLE consecutive cycles.
- Loads the stable word into the reference output register, then acknowledges the requester with a four-phase handshake.
- Sits between the flag-producing front ends and the downstream control loop that consumes ref.

Parameters:
- N, 8, flag word width per requester.
- R, 4, number of requesters (2..8).
- REF_W, 9, width of the ref output; the flag word is zero-extended into it (REF_W >= N).
- STABLE, 4, consecutive equal samples required for validity (>= 1).
- TIMEOUT, 64, max cycles in CHECK before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req  in  R  request per source; must stay high until its ack is seen.
- data_in  in  R*N  packed flag words; source i occupies bits [i*N +: N].
- ack  out  R  one-hot acknowledge to the granted source.
- ref  out  REF_W  registered validated reference word.
- ref_src  out  clog2(R)  index of the source that produced the current ref.
- ref_valid  out  1  one-cycle pulse when ref is updated.
- busy  out  1  high whenever the state is not IDLE.
- err  out  1  one-cycle timeout pulse; constant 0 when the feature is compiled out.

Behaviour:
- Reset (async assert, sync release): state=IDLE; ref=0, ref_src=0, ref_valid=0, ack=0, busy=0, err=0; last_grant=R-1; cnt=0; sample=0. A reset mid-transaction aborts it with no ack; ref returns to 0.
- IDLE:
  - If any req is high, grant the first high req searching upward (modulo R) from last_grant+1.
  - Latch the grant index, set sample = data_in of that source, set cnt=0, go to CHECK.
  - With no req high, stay in IDLE.
- CHECK, evaluated each edge on the granted source:
  - req[g] low: go to IDLE, set last_grant=g, no ack, ref unchanged.
  - data equals sample and cnt==STABLE-1: go to LOAD.
  - data equals sample, cnt below STABLE-1: cnt+1.
  - data differs from sample: sample=data, cnt=0. Any change restarts the count.
- LOAD, one cycle:
  - ref = {zeros, sample}, ref_src = g.
  - ref_valid=1 for exactly one cycle; ack[g]=1.
  - Go to ACK.
- ACK:
  - ack[g] stays high until req[g] is sampled low.
  - Then ack=0, last_grant=g, go to IDLE.
  - Other requests stay pending and are never dropped.
- Latency: IDLE samples req at edge E1. With steady data, ref, ref_valid and ack update at edge E(STABLE+2). Minimum spacing between two grants is STABLE+4 edges.
- Simultaneous requests are served strictly round-robin. A source can be regranted only after every other pending source has been served.
- data_in of non-granted sources is ignored. ref holds its value between updates.
- cnt width is clog2(STABLE+1); it never wraps.

Optional Feature:
- Macro: ARBITRO_TIMEOUT_EN.
- Defined:
  - A TIMEOUT-cycle counter runs in CHECK, cleared on entry.
  - When it reaches TIMEOUT-1 without entering LOAD: err=1 for one cycle, no ack, ref unchanged, last_grant=g, go to IDLE.
  - The requester must drop and reassert req to retry.
- Undefined: no timer logic, err tied to 0, CHECK may wait indefinitely.

Test Plan:
- Reset: hold reset=0 mid-CHECK, then release -> ref=0, ack=0, busy=0. Next req[1] with data 0x3C steady -> ref=0x03C, ref_src=1, ref_valid pulse at edge E6 (STABLE=4).
- Glitch: req[0], data 0x55 for 2 cycles, 0x54 for 1, then 0x55 steady -> count restarts twice; ref=0x055 only after 4 consecutive 0x55 samples.
- Fairness: req[0] and req[2] high together after reset -> ref_src 0 first, then 2. Assert req[0] again during ACK of 2 -> ack order 0, 2, 0.
- Handshake: hold req[3] high for 10 cycles after ack -> ack[3] stays high and no other grant occurs. Drop req -> ack low next edge, busy low.
- Abandon: drop req[1] during CHECK -> no ack, ref unchanged, pending req[2] granted next.
- Timeout (ARBITRO_TIMEOUT_EN, TIMEOUT=16): data toggles every cycle -> err pulse 16 cycles after entering CHECK, no ack, ref unchanged. Without the macro -> err stays 0, busy stays 1.
